// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data requesters onto one shared memory port
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          flush,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_mask,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_mask,
  input  logic          m_ready,
  input  logic          m_valid,
  input  logic [DW-1:0] m_rdata,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          resp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Watchdog only has to count up to TIMEOUT-1, one spare bit keeps the compare simple.
  localparam int             WDW     = $clog2(TIMEOUT) + 1;
  // The access expires on the edge that would take the counter to TIMEOUT-1.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  state_t         r_state;
  state_t         w_next;
  owner_t         r_owner;
  owner_t         r_last_grant;
  logic           r_drop;
  logic [WDW-1:0] r_wdog;

  logic w_if_pend;
  logic w_grant_any;
  logic w_grant_fetch;
  logic w_busy;
  logic w_resp;
  logic w_timeout;
  logic w_done;
  logic w_suppress;

  // A fetch presented together with a redirect is stale and must not be granted.
  assign w_if_pend     = if_req & ~flush;
  assign w_grant_any   = w_if_pend | d_req;
  // Data wins by default; fetch only wins a tie when data had the previous grant.
  assign w_grant_fetch = w_if_pend & (~d_req | (r_last_grant == OWN_DATA));

  assign w_busy     = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign w_resp     = (r_state == S_WAIT) & m_valid;
  // A response in the expiry cycle takes priority over the timeout.
  assign w_timeout  = w_busy & (r_wdog == WD_LAST) & ~w_resp;
  assign w_done     = w_resp | w_timeout;
  // A flush coinciding with completion also cancels the fetch pulse.
  assign w_suppress = (r_owner == OWN_FETCH) & (r_drop | flush);

  assign m_req = (r_state == S_ISSUE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_timeout) begin
          w_next = S_IDLE;
        end else if (m_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_done) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Grant capture, watchdog, drop tracking and registered responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner      <= OWN_FETCH;
      r_last_grant <= OWN_FETCH;
      r_drop       <= 1'b0;
      r_wdog       <= '0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_mask       <= '0;
      if_valid     <= 1'b0;
      if_rdata     <= '0;
      d_valid      <= 1'b0;
      d_rdata      <= '0;
      resp_err     <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      resp_err <= 1'b0;

      if (r_state == S_IDLE) begin
        if (w_grant_any) begin
          r_drop <= 1'b0;
          r_wdog <= '0;
          if (w_grant_fetch) begin
            r_owner      <= OWN_FETCH;
            r_last_grant <= OWN_FETCH;
            m_we         <= 1'b0;
            m_addr       <= if_addr;
            m_wdata      <= '0;
            m_mask       <= 4'hF;
          end else begin
            r_owner      <= OWN_DATA;
            r_last_grant <= OWN_DATA;
            m_we         <= d_we;
            m_addr       <= d_addr;
            m_wdata      <= d_wdata;
            m_mask       <= d_mask;
          end
        end
      end else if (w_busy) begin
        r_wdog <= r_wdog + WD_ONE;
        if (flush && (r_owner == OWN_FETCH)) begin
          r_drop <= 1'b1;
        end
        if (w_done) begin
          if (r_owner == OWN_DATA) begin
            d_valid  <= 1'b1;
            d_rdata  <= w_resp ? m_rdata : '0;
            resp_err <= w_timeout;
          end else if (!w_suppress) begin
            if_valid <= 1'b1;
            if_rdata <= w_resp ? m_rdata : '0;
            resp_err <= w_timeout;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          flush;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_mask;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_mask;
  logic          m_ready;
  logic          m_valid;
  logic [DW-1:0] m_rdata;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          resp_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_ready(m_ready), .m_valid(m_valid), .m_rdata(m_rdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .resp_err(resp_err)
  );

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   last_data = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if_valid || d_valid) begin
      chk("valid_exclusive", {63'd0, if_valid & d_valid}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", {62'd0, if_valid, d_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_chan", {63'd0, d_valid}, {63'd0, e.is_d});
        chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
        chk("resp_rdata", {32'd0, (d_valid ? d_rdata : if_rdata)}, {32'd0, e.rdata});
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One arbitration round starting in an IDLE cycle with the requests already driven.
  // r: ISSUE cycles before m_ready, k: cycles from m_ready to m_valid, flush_off: WAIT/ISSUE
  // cycle index carrying a flush (-1 for none), rd: read data returned.
  task automatic serve(input int r, input int k, input int flush_off, input logic [31:0] rd);
    bit          fp, dp, win_f, dropped, to;
    logic [31:0] ea, ewd;
    logic [3:0]  emk;
    logic        ewe;
    int          e_cyc, t, end_j;
    exp_t        e;
    fp = if_req && !flush;
    dp = d_req;
    if (!fp && !dp) begin
      step();
      flush = 1'b0;
      return;
    end
    win_f     = fp && (!dp || last_data);
    last_data = !win_f;
    if (win_f) begin
      ea = if_addr; ewe = 1'b0; ewd = '0; emk = 4'hF;
    end else begin
      ea = d_addr; ewe = d_we; ewd = d_wdata; emk = d_mask;
    end
    step();
    flush   = 1'b0;
    e_cyc   = cyc;
    t       = r + k;
    to      = (t > TIMEOUT - 2);
    end_j   = to ? TIMEOUT - 2 : t;
    dropped = 1'b0;
    for (int j = 0; j <= end_j; j++) begin
      chk("m_req_active", {63'd0, m_req}, {63'd0, (j <= r)});
      chk("m_addr_hold", {32'd0, m_addr}, {32'd0, ea});
      chk("m_we_hold", {63'd0, m_we}, {63'd0, ewe});
      if (!win_f) begin
        chk("m_wdata_hold", {32'd0, m_wdata}, {32'd0, ewd});
        chk("m_mask_hold", {60'd0, m_mask}, {60'd0, emk});
      end
      m_ready = (j == r);
      m_valid = (j == t) || ((j <= r) && ($urandom_range(0, 1) == 1));
      m_rdata = (j == t) ? rd : $urandom;
      flush   = (j == flush_off) && (j < end_j);
      if (flush && win_f) begin
        dropped = 1'b1;
        if_req  = 1'b0;
      end
      step();
    end
    m_ready = 1'b0;
    m_valid = 1'b0;
    flush   = 1'b0;
    chk("m_req_idle", {63'd0, m_req}, 64'd0);
    if (!dropped) begin
      e.is_d  = !win_f;
      e.err   = to;
      e.rdata = to ? 32'd0 : rd;
      e.cyc   = e_cyc + end_j + 1;
      sb.push_back(e);
    end
    if (win_f) if_req = 1'b0;
    else d_req = 1'b0;
  endtask

  task automatic new_reqs();
    if (!if_req && $urandom_range(0, 2) != 0) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!d_req && $urandom_range(0, 2) != 0) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_mask  = 4'($urandom_range(0, 15));
    end
    flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int r, k, fo;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_mask = '0;
    m_ready = 1'b0; m_valid = 1'b0; m_rdata = '0;
    repeat (3) step();
    chk("rst_m_req", {63'd0, m_req}, 64'd0);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_d_valid", {63'd0, d_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_m_we", {63'd0, m_we}, 64'd0);
    chk("rst_m_addr", {32'd0, m_addr}, 64'd0);
    chk("rst_m_wdata", {32'd0, m_wdata}, 64'd0);
    chk("rst_m_mask", {60'd0, m_mask}, 64'd0);
    chk("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
    chk("rst_d_rdata", {32'd0, d_rdata}, 64'd0);
    rst = 1'b1;
    step();

    // Single fetch, m_ready next cycle, m_valid two cycles later.
    if_req = 1'b1; if_addr = 32'h100;
    serve(0, 2, -1, 32'h0050_0093);

    // Simultaneous fetch and load: data first, then the held fetch.
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0; d_mask = 4'hF;
    serve(0, 1, -1, 32'h1111_2222);
    serve(1, 1, -1, 32'h3333_4444);

    // Fetch flushed in WAIT, m_valid three cycles after the flush.
    if_req = 1'b1; if_addr = 32'h400;
    serve(0, 4, 1, 32'hBAD0_BAD0);
    chk("flush_no_if_valid", {63'd0, if_valid}, 64'd0);

    // Store with m_ready held off for four cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_mask = 4'h3;
    serve(4, 2, -1, 32'h0);

    // Load that never gets a response times out.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; d_wdata = '0; d_mask = 4'hF;
    serve(0, 100, -1, 32'h7777_7777);

    // Response arriving in the expiry cycle wins over the timeout.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5004;
    serve(3, 11, -1, 32'hCAFE_F00D);

    // Timeout while m_ready never comes.
    if_req = 1'b1; if_addr = 32'h600;
    serve(20, 1, -1, 32'h0);

    // Reset in the middle of WAIT, then a late m_valid.
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b0; flush = 1'b0;
    step();
    chk("rstw_m_req_issue", {63'd0, m_req}, 64'd1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("rstw_m_req_wait", {63'd0, m_req}, 64'd0);
    rst = 1'b0; if_req = 1'b0;
    step();
    rst = 1'b1;
    last_data = 1'b0;
    chk("rstw_m_req", {63'd0, m_req}, 64'd0);
    chk("rstw_if_rdata", {32'd0, if_rdata}, 64'd0);
    m_valid = 1'b1; m_rdata = 32'h9999_9999;
    step();
    m_valid = 1'b0;
    chk("rstw_late_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rstw_m_req_after", {63'd0, m_req}, 64'd0);
    step();
    chk("rstw_late_if_valid2", {63'd0, if_valid}, 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      new_reqs();
      r  = $urandom_range(0, 3);
      k  = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 20) : $urandom_range(1, 4);
      fo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      serve(r, k, fo, $urandom);
    end

    if_req = 1'b0; d_req = 1'b0; flush = 1'b0;
    repeat (3) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
